gray_frame_stats: RTL
=====================

GRAY_FRAME_STATS -- requirements
Module: gray_frame_stats

Interface
REQ-001 Parameter IMG_W, default 500, pixels per line.
REQ-002 Parameter IMG_H, default 500, lines per frame.
REQ-003 Parameter DW, default 32, pixel word width (matches converter output word).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; arms capture of one frame.
REQ-007 thresh  input  DW  threshold for bright-pixel count; sampled on accepted start.
REQ-008 in_valid  input  1  upstream pixel word valid.
REQ-009 in_data  input  DW  converted pixel word, unsigned.
REQ-010 in_ready  output  1  block accepts a pixel this cycle.
REQ-011 pix_x  output  16  column index of the next pixel to be accepted.
REQ-012 pix_y  output  16  row index of the next pixel to be accepted.
REQ-013 busy  output  1  high while in state RUN.
REQ-014 frame_done  output  1  one-cycle pulse when frame statistics become final.
REQ-015 stats_valid  output  1  min/max/sum/bright hold a completed frame.
REQ-016 min_val  output  DW  smallest pixel of the frame.
REQ-017 max_val  output  DW  largest pixel of the frame.
REQ-018 sum_val  output  DW+18  unsigned sum of all pixels; no overflow at 500x500.
REQ-019 bright_cnt  output  18  number of pixels with in_data >= thresh.

Function
REQ-020 States IDLE, RUN, DONE; the state register is the only control state.
REQ-021 IDLE: in_ready=0; start=1 -> RUN next cycle; sets pix_x=pix_y=0, min_val=all-ones, max_val=0, sum_val=0, bright_cnt=0, stats_valid=0, latches thresh.
REQ-022 RUN: in_ready=1 combinationally from state only (no dependence on in_valid).
REQ-023 Accept = in_valid && in_ready; each accept updates min/max/sum/bright in the same edge (registered, 1-cycle latency to outputs).
REQ-024 On accept pix_x increments; pix_x==IMG_W-1 wraps to 0 and pix_y increments.
REQ-025 Accept with pix_x==IMG_W-1 and pix_y==IMG_H-1 -> DONE; pix_x/pix_y wrap to 0.
REQ-026 in_valid low in RUN: no counter or statistic change (stall of any length allowed).
REQ-027 DONE lasts exactly one cycle: frame_done=1, stats_valid set to 1, in_ready=0, then -> IDLE.
REQ-028 Statistics and stats_valid hold unchanged in IDLE until the next accepted start.
REQ-029 start while in RUN or DONE is ignored; it does not restart or abort the frame.
REQ-030 start and in_valid together in IDLE: start taken, pixel not accepted (in_ready=0).
REQ-031 Equality cases: in_data==thresh counts as bright; in_data equal to current min/max leaves it unchanged.
REQ-032 Sum arithmetic unsigned, zero-extended in_data, no saturation needed.

Reset
REQ-033 rst_n low asynchronously forces IDLE, in_ready=0, busy=0, frame_done=0, stats_valid=0, pix_x=pix_y=0, min_val=all-ones, max_val=0, sum_val=0, bright_cnt=0, latched thresh=0.
REQ-034 Reset mid-frame discards the partial frame; no frame_done is issued for it.
REQ-035 After rst_n rises, the block stays in IDLE until a start pulse.

Verification (bench runs IMG_W=4, IMG_H=2 unless noted)
REQ-036 start, thresh=10, pixels 5,12,3,10,7,20,1,9 back-to-back -> frame_done 1 cycle after 8th accept; min=1, max=20, sum=67, bright=3, stats_valid=1.
REQ-037 Same frame with in_valid low 3 cycles after each pixel -> identical statistics; pix_x/pix_y hold during stalls.
REQ-038 start pulse during RUN after 3 pixels -> ignored; frame completes after 8 accepts total, statistics cover all 8.
REQ-039 rst_n low after 5 accepts -> all outputs at reset values immediately; no frame_done; a new start then runs a full clean frame.
REQ-040 Two frames: second frame all pixels 0xFFFFFFFF, thresh=0xFFFFFFFF -> min=max=0xFFFFFFFF, sum=8*0xFFFFFFFF, bright=8; first frame stats held until second start.
REQ-041 Default parameters, 250000 pixels of 0xFFFFFFFF -> sum_val=250000*0xFFFFFFFF without overflow, bright_cnt=250000.

Source files
------------

// File: rtl/gray_frame_stats_if.sv
// gray_frame_stats_if: pixel stream handshake between a converter and the frame statistics block
interface gray_frame_stats_if #(
    parameter int DW = 32
) ();
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/gray_frame_stats.sv
// gray_frame_stats: captures one frame of pixels and reports min, max, sum and bright-pixel count
module gray_frame_stats #(
    parameter int IMG_W = 500,
    parameter int IMG_H = 500,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW-1:0]    thresh,
    gray_frame_stats_if.slave pix,
    output logic [15:0]      pix_x,
    output logic [15:0]      pix_y,
    output logic             busy,
    output logic             frame_done,
    output logic             stats_valid,
    output logic [DW-1:0]    min_val,
    output logic [DW-1:0]    max_val,
    output logic [DW+17:0]   sum_val,
    output logic [17:0]      bright_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [15:0]     pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic            frame_done_q, frame_done_d, stats_valid_q, stats_valid_d;
    logic [DW-1:0]   min_q, min_d, max_q, max_d, thr_q, thr_d;
    logic [DW+17:0]  sum_q, sum_d;
    logic [17:0]     bright_q, bright_d;
    logic            accept, last_x, last_y;

    // next-state and statistics update; only RUN accepts pixels, IDLE arms a fresh frame on start
    always_comb begin
        accept        = pix.in_valid && (state_q == RUN);
        last_x        = pix_x_q == 16'(IMG_W - 1);
        last_y        = pix_y_q == 16'(IMG_H - 1);
        state_d       = state_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_done_d  = 1'b0;
        stats_valid_d = stats_valid_q;
        min_d         = min_q;
        max_d         = max_q;
        sum_d         = sum_q;
        bright_d      = bright_q;
        thr_d         = thr_q;
        case (state_q)
            IDLE: if (start) begin
                state_d       = RUN;
                pix_x_d       = '0;
                pix_y_d       = '0;
                min_d         = '1;
                max_d         = '0;
                sum_d         = '0;
                bright_d      = '0;
                stats_valid_d = 1'b0;
                thr_d         = thresh;
            end
            RUN: if (accept) begin
                min_d    = pix.in_data < min_q ? pix.in_data : min_q;
                max_d    = pix.in_data > max_q ? pix.in_data : max_q;
                sum_d    = sum_q + (DW+18)'(pix.in_data);
                bright_d = bright_q + 18'(pix.in_data >= thr_q);
                pix_x_d  = last_x ? 16'd0 : pix_x_q + 16'd1;
                pix_y_d  = last_x ? (last_y ? 16'd0 : pix_y_q + 16'd1) : pix_y_q;
                if (last_x && last_y) begin
                    state_d       = DONE;
                    frame_done_d  = 1'b1;
                    stats_valid_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and statistics registers; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_done_q  <= 1'b0;
            stats_valid_q <= 1'b0;
            min_q         <= '1;
            max_q         <= '0;
            sum_q         <= '0;
            bright_q      <= '0;
            thr_q         <= '0;
        end else begin
            state_q       <= state_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_done_q  <= frame_done_d;
            stats_valid_q <= stats_valid_d;
            min_q         <= min_d;
            max_q         <= max_d;
            sum_q         <= sum_d;
            bright_q      <= bright_d;
            thr_q         <= thr_d;
        end
    end

    assign pix.in_ready = state_q == RUN;
    assign busy         = state_q == RUN;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign frame_done   = frame_done_q;
    assign stats_valid  = stats_valid_q;
    assign min_val      = min_q;
    assign max_val      = max_q;
    assign sum_val      = sum_q;
    assign bright_cnt   = bright_q;
endmodule
